// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the WISC memory-access stage: FSM encodings and widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_access_stage_pkg;

    // Default data/address width of the 16-bit datapath.
    localparam int DATA_W_DEF = 16;

    // Register-file index width (16 architectural registers).
    localparam int REG_IDX_W = 4;

    // Memory-stage FSM states.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/mem_access_stage_lsu_timeout_counter.sv
// Watchdog counter for an outstanding data-memory access.
// Latency: expire is combinational in the TIMEOUT_CYCLES-th enabled cycle after clear.
// Backpressure: none; the counter saturates instead of wrapping.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   clr     restart the count (takes priority over en)
//   en      count this cycle (stage is waiting for mem_ack)
//   expire  this enabled cycle is the last one allowed without an ack
module lsu_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // The count reaches TIMEOUT_CYCLES at the end of this cycle, so the
    // request has been visible for exactly TIMEOUT_CYCLES cycles.
    assign expire = en && (cnt == CNT_LAST);

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage of the WISC datapath: runs LW/SW over a req/ack port and retires one result per instruction.
// Latency: non-memory ops 1 cycle; LW/SW accept -> >=1 mem_req cycle -> wb_valid the cycle after mem_ack.
// Backpressure: ex_ready is low while an access is in flight and permanently after HLT retires.
//
// Optional feature macro: LSU_ALIGN_CHECK_EN
//   defined   : LW/SW with address bit 0 set issues no access and retires with err.
//   undefined : address bit 0 is forced to zero; alignment never raises err.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   ex_valid/ex_ready                 instruction handshake from execute
//   ex_alu_res, ex_wdata              address/ALU value and store data
//   ex_mem_rd, ex_mem_wr, ex_reg_we   LW, SW, register-write flags
//   ex_rd, ex_halt                    destination register, HLT flag
//   mem_req/mem_ack                   data-memory request held until ack or abort
//   mem_we, mem_addr, mem_wdata       request attributes, stable while mem_req
//   mem_rdata                         load data, valid with mem_ack
//   wb_valid, wb_we, wb_rd, wb_data   one-cycle retire pulse to writeback
//   err                               one-cycle pulse: timeout, rd+wr conflict, misalignment
//   halted                            sticky after HLT retires
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic [DATA_W-1:0]    ex_alu_res,
    input  logic [DATA_W-1:0]    ex_wdata,
    input  logic                 ex_mem_rd,
    input  logic                 ex_mem_wr,
    input  logic                 ex_reg_we,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_halt,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [DATA_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic                 mem_ack,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 wb_valid,
    output logic                 wb_we,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [DATA_W-1:0]    wb_data,
    output logic                 err,
    output logic                 halted
);

    lsu_state_t state, state_d;

    logic [REG_IDX_W-1:0] rd_q, rd_d;
    logic                 mem_req_d, mem_we_d;
    logic [DATA_W-1:0]    mem_addr_d, mem_wdata_d;
    logic                 wb_valid_d, wb_we_d, err_d, halted_d;
    logic [REG_IDX_W-1:0] wb_rd_d;
    logic [DATA_W-1:0]    wb_data_d;

    logic                 accept;
    logic                 is_mem_op;
    logic                 misaligned;
    logic [DATA_W-1:0]    req_addr;
    logic                 cnt_clr;
    logic                 cnt_en;
    logic                 timeout;

    assign ex_ready  = (state == ST_IDLE) && !halted;
    assign accept    = ex_valid && ex_ready;
    assign is_mem_op = ex_mem_rd || ex_mem_wr;

`ifdef LSU_ALIGN_CHECK_EN
    assign misaligned = ex_alu_res[0];
    assign req_addr   = ex_alu_res;
`else
    assign misaligned = 1'b0;
    assign req_addr   = {ex_alu_res[DATA_W-1:1], 1'b0};
`endif

    assign cnt_en = (state == ST_ACCESS);

    lsu_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .expire (timeout)
    );

    // Next-state and next-output logic. wb_valid and err are pulses; the other
    // writeback fields hold their last value and are qualified by wb_valid.
    always_comb begin
        state_d     = state;
        rd_d        = rd_q;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        wb_valid_d  = 1'b0;
        err_d       = 1'b0;
        wb_we_d     = wb_we;
        wb_rd_d     = wb_rd;
        wb_data_d   = wb_data;
        halted_d    = halted;
        cnt_clr     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (ex_mem_rd && ex_mem_wr) begin
                        // Ambiguous memory op: drop it and flag it.
                        wb_valid_d = 1'b1;
                        wb_we_d    = 1'b0;
                        wb_rd_d    = ex_rd;
                        wb_data_d  = '0;
                        err_d      = 1'b1;
                    end else if (ex_halt) begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = 1'b0;
                        wb_rd_d    = ex_rd;
                        wb_data_d  = '0;
                        halted_d   = 1'b1;
                    end else if (is_mem_op && misaligned) begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = 1'b0;
                        wb_rd_d    = ex_rd;
                        wb_data_d  = '0;
                        err_d      = 1'b1;
                    end else if (is_mem_op) begin
                        state_d     = ST_ACCESS;
                        rd_d        = ex_rd;
                        mem_we_d    = ex_mem_wr;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = ex_wdata;
                        cnt_clr     = 1'b1;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = ex_reg_we;
                        wb_rd_d    = ex_rd;
                        wb_data_d  = ex_alu_res;
                    end
                end
            end

            ST_ACCESS: begin
                // An ack arriving in the expiry cycle still completes normally.
                if (mem_ack) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_we_d    = !mem_we;
                    wb_rd_d    = rd_q;
                    wb_data_d  = mem_we ? '0 : mem_rdata;
                end else if (timeout) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_we_d    = 1'b0;
                    wb_rd_d    = rd_q;
                    wb_data_d  = '0;
                    err_d      = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        mem_req_d = (state_d == ST_ACCESS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rd_q      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            err       <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= state_d;
            rd_q      <= rd_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            wb_valid  <= wb_valid_d;
            wb_we     <= wb_we_d;
            wb_rd     <= wb_rd_d;
            wb_data   <= wb_data_d;
            err       <= err_d;
            halted    <= halted_d;
        end
    end

endmodule
